// File: rtl/hud_snapshot_reader.sv
// Purpose : once per frame, sweep the display words of the game register RAM into
//           staging regs, then commit them all at once so the drawer never shows a torn frame.
// Latency : frame_start at T -> reads T+1..T+25, commit_pulse/new outputs at T+26+READ_LATENCY.
// Backpr. : none; one read per cycle, frame_start outside IDLE is dropped and flagged via overrun.
//
// Ports:
//   CLK, RESET_n        clock, synchronous active-low reset
//   frame_start         vblank start pulse; accepted only in IDLE
//   ram_addr/ram_rd     RAM port-B read request (registered)
//   ram_rdata           read data, valid READ_LATENCY cycles after ram_rd
//   *_q                 committed words (0x000, 0x001, 0x016, 0x800, 0x801)
//   row_idx/row_data    committed board row lookup, 0 for row_idx >= NUM_ROWS
//   snapshot_valid      at least one commit since reset
//   commit_pulse        high in the cycle the committed outputs take new values
//   busy                high from the cycle after acceptance through the commit cycle
//   overrun             combinational: frame_start seen while not IDLE

module hud_snapshot_reader #(
    parameter int READ_LATENCY = 2,
    parameter int NUM_ROWS     = 20
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        frame_start,
    output logic [11:0] ram_addr,
    output logic        ram_rd,
    input  logic [31:0] ram_rdata,
    output logic [31:0] level_lines_q,
    output logic [31:0] score_q,
    output logic [31:0] next_q,
    output logic [31:0] palette_q,
    output logic [31:0] window_q,
    input  logic [4:0]  row_idx,
    output logic [31:0] row_data,
    output logic        snapshot_valid,
    output logic        commit_pulse,
    output logic        busy,
    output logic        overrun
);

    // Word index layout: 0 level/lines, 1 score, 2..NUM_ROWS+1 rows,
    // NUM_ROWS+2 next piece, NUM_ROWS+3 palette, NUM_ROWS+4 window.
    localparam int         NUM_WORDS = NUM_ROWS + 5;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_WORDS - 1);
    localparam int         NEXT_IDX  = NUM_ROWS + 2;
    localparam int         PAL_IDX   = NUM_ROWS + 3;
    localparam int         WIN_IDX   = NUM_ROWS + 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  issue_idx;

    // Read-return tracking: {valid, index} travels alongside each outstanding read.
    logic        pipe_vld [READ_LATENCY];
    logic [4:0]  pipe_idx [READ_LATENCY];
    logic        tail_vld;
    logic [4:0]  tail_idx;
    logic        last_back;

    logic [31:0] stage_q   [NUM_WORDS];
    logic [31:0] stage_nxt [NUM_WORDS];
    logic [31:0] commit_q  [NUM_WORDS];

    // Index-to-address map; words 0x017..0x01B are never generated.
    function automatic logic [11:0] word_addr(input logic [4:0] idx);
        if (idx == 5'(PAL_IDX))
            return 12'h800;
        else if (idx == 5'(WIN_IDX))
            return 12'h801;
        else
            return {7'd0, idx};
    endfunction

    assign tail_vld  = pipe_vld[READ_LATENCY-1];
    assign tail_idx  = pipe_idx[READ_LATENCY-1];
    // Reads return in order, so the last index coming back means nothing is outstanding.
    assign last_back = tail_vld && (tail_idx == LAST_IDX);

    // Staging with the returning word folded in. The commit copies this view so the
    // final word lands in the committed regs on the same edge it is captured.
    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            stage_nxt[k] = stage_q[k];
            if (tail_vld && (tail_idx == 5'(k)))
                stage_nxt[k] = ram_rdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state          <= IDLE;
            issue_idx      <= '0;
            ram_rd         <= 1'b0;
            ram_addr       <= '0;
            busy           <= 1'b0;
            commit_pulse   <= 1'b0;
            snapshot_valid <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
            for (int k = 0; k < NUM_WORDS; k++) begin
                stage_q[k]  <= '0;
                commit_q[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= ram_rd;
            pipe_idx[0] <= issue_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            for (int k = 0; k < NUM_WORDS; k++)
                stage_q[k] <= stage_nxt[k];

            commit_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state     <= ISSUE;
                        issue_idx <= '0;
                        ram_rd    <= 1'b1;
                        ram_addr  <= word_addr(5'd0);
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_idx == LAST_IDX) begin
                        state    <= DRAIN;
                        ram_rd   <= 1'b0;
                        ram_addr <= '0;
                    end else begin
                        issue_idx <= issue_idx + 5'd1;
                        ram_addr  <= word_addr(issue_idx + 5'd1);
                    end
                end
                DRAIN: begin
                    if (last_back) begin
                        state          <= COMMIT;
                        commit_pulse   <= 1'b1;
                        snapshot_valid <= 1'b1;
                        for (int k = 0; k < NUM_WORDS; k++)
                            commit_q[k] <= stage_nxt[k];
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ram_rd <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Any frame_start outside IDLE (including the commit cycle) is dropped.
    assign overrun = frame_start && (state != IDLE);

    assign level_lines_q = commit_q[0];
    assign score_q       = commit_q[1];
    assign next_q        = commit_q[NEXT_IDX];
    assign palette_q     = commit_q[PAL_IDX];
    assign window_q      = commit_q[WIN_IDX];

    always_comb begin
        row_data = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_idx == 5'(r))
                row_data = commit_q[r+2];
        end
    end

endmodule
